// File: rtl/mem_arbiter_pkg.sv
// Shared defines for the memory subsystem: memory access modes, ALU opcodes
// and the read-owner encoding used by the RAM port arbiter.
package mem_arbiter_pkg;

  // Load/store access sizes
  localparam logic [1:0] MEM_MODE_BYTE = 2'd0;
  localparam logic [1:0] MEM_MODE_HALF = 2'd1;
  localparam logic [1:0] MEM_MODE_WORD = 2'd2;

  // ALU operation codes
  localparam logic [3:0] ALU_OP_ADD = 4'd0;
  localparam logic [3:0] ALU_OP_SUB = 4'd1;
  localparam logic [3:0] ALU_OP_AND = 4'd2;
  localparam logic [3:0] ALU_OP_OR  = 4'd3;
  localparam logic [3:0] ALU_OP_XOR = 4'd4;
  localparam logic [3:0] ALU_OP_SLL = 4'd5;
  localparam logic [3:0] ALU_OP_SRL = 4'd6;

  // Which requester owns the read data returning from RAM this cycle
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } rd_owner_e;

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester (CPU / DMA) arbiter for a single synchronous RAM port.
// CPU has priority; a DMA request that keeps losing is forced through once
// it has waited STARVE_LIMIT cycles. Read data returns one cycle after the
// grant and is steered to whichever requester issued the read.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset_n,

  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_byteen,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rdata,

  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  input  logic [3:0]  dma_byteen,
  output logic        dma_gnt,
  output logic        dma_rvalid,
  output logic [31:0] dma_rdata,

  output logic [29:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic [3:0]  ram_byteen,
  output logic        ram_wren,
  input  logic [31:0] ram_q
);

  // Counter is at least 3 bits, wider only if the limit needs it
  localparam int WCW = ($clog2(STARVE_LIMIT + 1) > 3) ? $clog2(STARVE_LIMIT + 1) : 3;
  localparam logic [WCW-1:0] LIMIT = WCW'(STARVE_LIMIT);

  logic [WCW-1:0] wait_cnt;
  rd_owner_e      rd_owner;
  logic [31:0]    cpu_rdata_q;
  logic [31:0]    dma_rdata_q;
  logic           cpu_win;
  logic           dma_win;

  // Byte offset bits are not used: RAM is word addressed
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{cpu_addr[1:0], dma_addr[1:0]};

  // Priority decision: CPU first, DMA once it has starved long enough
  always_comb begin
    dma_win = dma_req && (!cpu_req || (wait_cnt == LIMIT));
    cpu_win = cpu_req && !dma_win;
  end

  // Grants are forced low while reset is held, independent of the clock
  assign cpu_gnt = reset_n & cpu_win;
  assign dma_gnt = reset_n & dma_win;

  // Steer the granted requester onto the RAM port; idle port reads full words
  always_comb begin
    ram_addr   = cpu_addr[31:2];
    ram_wdata  = cpu_wdata;
    ram_byteen = 4'b1111;
    ram_wren   = 1'b0;
    if (dma_gnt) begin
      ram_addr   = dma_addr[31:2];
      ram_wdata  = dma_wdata;
      ram_byteen = dma_we ? dma_byteen : 4'b1111;
      ram_wren   = dma_we;
    end else if (cpu_gnt) begin
      ram_addr   = cpu_addr[31:2];
      ram_wdata  = cpu_wdata;
      ram_byteen = cpu_we ? cpu_byteen : 4'b1111;
      ram_wren   = cpu_we;
    end
  end

  // Count consecutive cycles a pending DMA request has lost, saturating
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
    end else if (dma_req && !dma_gnt) begin
      if (wait_cnt != LIMIT) wait_cnt <= wait_cnt + 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

  // Remember who issued this cycle's read so the returning data is steered
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_owner <= OWN_NONE;
    end else if (cpu_gnt && !cpu_we) begin
      rd_owner <= OWN_CPU;
    end else if (dma_gnt && !dma_we) begin
      rd_owner <= OWN_DMA;
    end else begin
      rd_owner <= OWN_NONE;
    end
  end

  // Capture returning words so each rdata holds while the other port reads
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      if (rd_owner == OWN_CPU) cpu_rdata_q <= ram_q;
      if (rd_owner == OWN_DMA) dma_rdata_q <= ram_q;
    end
  end

  assign cpu_rvalid = (rd_owner == OWN_CPU);
  assign dma_rvalid = (rd_owner == OWN_DMA);
  assign cpu_rdata  = cpu_rvalid ? ram_q : cpu_rdata_q;
  assign dma_rdata  = dma_rvalid ? ram_q : dma_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by randomized traffic,
// checked cycle by cycle against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int STARVE = 4;

  logic        clk;
  logic        reset_n;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic [3:0]  cpu_byteen, dma_byteen;
  logic        cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid;
  logic [31:0] cpu_rdata, dma_rdata;
  logic [29:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_byteen;
  logic        ram_wren;
  logic [31:0] ram_q;

  mem_arbiter #(.STARVE_LIMIT(STARVE)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_byteen(cpu_byteen), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_byteen(dma_byteen), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_byteen(ram_byteen),
    .ram_wren(ram_wren), .ram_q(ram_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM environment: one-cycle read latency, byte-enabled writes
  logic [31:0] ram_mem [0:1023];
  initial ram_q = '0;
  always @(posedge clk) begin
    ram_q <= ram_mem[ram_addr[9:0]];
    if (ram_wren)
      for (int b = 0; b < 4; b++)
        if (ram_byteen[b]) ram_mem[ram_addr[9:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
  end

  // Reference model state
  logic [31:0] mmem [0:1023];
  int          losses;
  int          pend_own;      // 0 none, 1 cpu, 2 dma
  logic [31:0] pend_data;
  logic [31:0] last_c, last_d;
  bit          m_cgnt, m_dgnt;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic mem_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    for (int b = 0; b < 4; b++)
      if (be[b]) mmem[a[11:2]][8*b +: 8] = d[8*b +: 8];
  endtask

  // One clock cycle: drive at the falling edge, check 1 ns later, advance model
  task automatic cycle(input bit rst,
                       input bit c_req, input bit c_we, input logic [31:0] c_addr,
                       input logic [31:0] c_wd, input logic [3:0] c_be,
                       input bit d_req, input bit d_we, input logic [31:0] d_addr,
                       input logic [31:0] d_wd, input logic [3:0] d_be);
    @(negedge clk);
    reset_n = rst;
    cpu_req = c_req; cpu_we = c_we; cpu_addr = c_addr; cpu_wdata = c_wd; cpu_byteen = c_be;
    dma_req = d_req; dma_we = d_we; dma_addr = d_addr; dma_wdata = d_wd; dma_byteen = d_be;
    #1;
    if (!rst) begin
      chk("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
      chk("rst_dma_gnt", 32'(dma_gnt), 32'd0);
      chk("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
      chk("rst_dma_rvalid", 32'(dma_rvalid), 32'd0);
      chk("rst_ram_wren", 32'(ram_wren), 32'd0);
      chk("rst_cpu_rdata", cpu_rdata, 32'd0);
      chk("rst_dma_rdata", dma_rdata, 32'd0);
      losses = 0; pend_own = 0; last_c = '0; last_d = '0;
      m_cgnt = 0; m_dgnt = 0;
      return;
    end

    // Read data returning from the previous cycle's grant
    if (pend_own == 1) last_c = pend_data;
    if (pend_own == 2) last_d = pend_data;
    chk("cpu_rvalid", 32'(cpu_rvalid), 32'(pend_own == 1));
    chk("dma_rvalid", 32'(dma_rvalid), 32'(pend_own == 2));
    chk("cpu_rdata", cpu_rdata, last_c);
    chk("dma_rdata", dma_rdata, last_d);

    // Who gets the port this cycle
    if (c_req && d_req) begin
      m_dgnt = (losses >= STARVE);
      m_cgnt = !m_dgnt;
    end else begin
      m_cgnt = c_req;
      m_dgnt = d_req;
    end
    chk("cpu_gnt", 32'(cpu_gnt), 32'(m_cgnt));
    chk("dma_gnt", 32'(dma_gnt), 32'(m_dgnt));

    if (m_cgnt || m_dgnt) begin
      logic        w;
      logic [31:0] a, wd;
      logic [3:0]  be;
      w  = m_cgnt ? c_we   : d_we;
      a  = m_cgnt ? c_addr : d_addr;
      wd = m_cgnt ? c_wd   : d_wd;
      be = m_cgnt ? c_be   : d_be;
      chk("ram_addr", 32'(ram_addr), a >> 2);
      chk("ram_wren", 32'(ram_wren), 32'(w));
      chk("ram_byteen", 32'(ram_byteen), w ? 32'(be) : 32'hF);
      if (w) begin
        chk("ram_wdata", ram_wdata, wd);
        mem_write(a, wd, be);
        pend_own = 0;
      end else begin
        pend_own  = m_cgnt ? 1 : 2;
        pend_data = mmem[a[11:2]];
      end
    end else begin
      chk("idle_ram_wren", 32'(ram_wren), 32'd0);
      chk("idle_ram_byteen", 32'(ram_byteen), 32'hF);
      pend_own = 0;
    end

    if (d_req && !m_dgnt) losses = (losses + 1 > STARVE) ? STARVE : losses + 1;
    else                  losses = 0;
  endtask

  task automatic idle();
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bit          cr, cw, dr, dw, rst;
    logic [31:0] ca, cwd, da, dwd;
    logic [3:0]  cbe, dbe;

    for (int i = 0; i < 1024; i++) begin
      ram_mem[i] = $urandom;
      mmem[i]    = ram_mem[i];
    end
    ram_mem[2] = 32'hDEADBEEF;
    mmem[2]    = 32'hDEADBEEF;
    reset_n = 0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; cpu_byteen = 0;
    dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0; dma_byteen = 0;
    losses = 0; pend_own = 0; pend_data = 0; last_c = 0; last_d = 0;

    // Reset state
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 32'h10, 0, 0, 1, 0, 32'h20, 0, 0);

    // CPU-only read of preloaded word, granted on the first cycle after reset
    cycle(1, 1, 0, 32'h0001_0008, 0, 4'h0, 0, 0, 0, 0, 0);
    chk("cpu_read_ram_addr", 32'(ram_addr), 32'h0004002);
    idle();
    chk("cpu_read_data", cpu_rdata, 32'hDEADBEEF);

    // Contention: CPU wins four times, then DMA, repeating
    for (int i = 0; i < 15; i++) begin
      cycle(1, 1, 0, 32'h40, 0, 0, 1, 0, 32'h80, 0, 0);
      chk("contention_seq", 32'(cpu_gnt), 32'((i % 5) != 4));
    end
    idle();

    // DMA byte-lane write, CPU idle; then read it back
    cycle(1, 0, 0, 0, 0, 0, 1, 1, 32'h0001_0000, 32'h00AB_0000, 4'b0100);
    chk("dma_wr_byteen", 32'(ram_byteen), 32'h4);
    cycle(1, 0, 0, 0, 0, 0, 1, 0, 32'h0001_0000, 0, 0);
    idle();

    // Interleaved reads on consecutive cycles
    cycle(1, 1, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 1, 0, 32'h4, 0, 0);
    idle();
    idle();

    // Reset one cycle after a CPU read grant, then normal operation
    cycle(1, 1, 0, 32'h8, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 32'hC, 0, 0, 0, 0, 0, 0, 0);
    idle();

    // Randomized traffic: requests held until granted, occasionally dropped
    cr = 0; dr = 0;
    cw = 0; ca = 0; cwd = 0; cbe = 0; dw = 0; da = 0; dwd = 0; dbe = 0;
    for (int i = 0; i < 800; i++) begin
      if (!cr) begin
        cr = ($urandom_range(2, 0) != 0); cw = $urandom_range(1, 0) == 1;
        ca = $urandom; cwd = $urandom; cbe = 4'($urandom);
      end
      if (!dr) begin
        dr = ($urandom_range(2, 0) != 0); dw = $urandom_range(1, 0) == 1;
        da = $urandom; dwd = $urandom; dbe = 4'($urandom);
      end
      rst = ($urandom_range(120, 0) != 0);
      cycle(rst, cr, cw, ca, cwd, cbe, dr, dw, da, dwd, dbe);
      if (!rst || m_cgnt || $urandom_range(15, 0) == 0) cr = 0;
      if (!rst || m_dgnt || $urandom_range(15, 0) == 0) dr = 0;
    end
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
